// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the apb_slave register-file completer.
package apb_slave_pkg;

    localparam int DATA_W        = 32;
    localparam int ADDR_W        = 32;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_slave_if.sv
// APB bus bundle between a requester (master modport) and the apb_slave completer.
interface apb_slave_if;
    import apb_slave_pkg::*;

    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x 32 storage with asynchronous clear, synchronous write port and a
// registered-capture read port whose output holds until the next capture.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // Every word must read back as zero after reset, so the array is cleared.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_reg[rd_idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/apb_slave.sv
// APB3-style completer: IDLE/SETUP/ACCESS tracking FSM in front of a word register file.
// Define APB_SLAVE_WAIT_EN to insert one wait state into every transfer.
module apb_slave
    import apb_slave_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_slave_if.slave bus
);

`ifdef APB_SLAVE_WAIT_EN
    localparam bit WAIT_MODE = 1'b1;
`else
    localparam bit WAIT_MODE = 1'b0;
`endif

    apb_state_t        state_reg;
    apb_state_t        state_next;
    logic              wait_done;
    logic              pready;
    logic              wr_en;
    logic              rd_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_data;
    logic              addr_unused;

    // Upper address bits are ignored, so addresses alias modulo DEPTH.
    assign idx         = bus.PADDR[IDX_W-1:0];
    assign addr_unused = ^bus.PADDR[ADDR_W-1:IDX_W];

`ifdef APB_SLAVE_WAIT_EN
    logic wait_cnt_reg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_reg <= 1'b0;
        end else if (state_reg != ACCESS) begin
            wait_cnt_reg <= 1'b0;
        end else if (bus.PSELx && bus.PENABLE) begin
            wait_cnt_reg <= 1'b1;
        end
    end

    assign wait_done = wait_cnt_reg;
`else
    assign wait_done = 1'b1;
`endif

    assign pready = (state_reg == ACCESS) && bus.PSELx && bus.PENABLE && wait_done;
    assign wr_en  = pready && bus.PWRITE;
    assign rd_en  = (state_reg == SETUP) && bus.PSELx && !bus.PWRITE;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!bus.PSELx) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // PENABLE already high here is a protocol violation: stay put.
                    if (!bus.PENABLE) begin
                        state_next = SETUP;
                    end
                end
                SETUP: begin
                    state_next = ACCESS;
                end
                ACCESS: begin
                    if (WAIT_MODE && bus.PENABLE && !wait_done) begin
                        state_next = ACCESS;
                    end else if (!bus.PENABLE) begin
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    apb_slave_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (bus.PWDATA),
        .rd_en   (rd_en),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    assign bus.PRDATA = rd_data;
    assign bus.PREADY = pready;

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: scoreboard of expected read data checked when PREADY completes a transfer.
module tb_apb_slave;
    import apb_slave_pkg::*;

`ifdef APB_SLAVE_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 1;
`endif

    logic pclk;
    logic presetn;

    apb_slave_if apb ();

    apb_slave #(
        .DEPTH (32),
        .IDX_W (5)
    ) dut (
        .PCLK    (pclk),
        .PRESETn (presetn),
        .bus     (apb)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Starts at #1 after a rising edge; returns at #1 after the completing edge with the bus idle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input bit hold, input string tag);
        int          waits;
        logic [31:0] exp_rd;
        if (!wr) exp_q.push_back(model[addr[4:0]]);
        apb.PSELx   = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        @(posedge pclk); #1;
        apb.PENABLE = 1'b1;
        waits = 0;
        @(negedge pclk);
        while (apb.PREADY !== 1'b1 && waits < 8) begin
            waits++;
            @(negedge pclk);
        end
        check({tag, " wait_cycles"}, 32'(waits), 32'(EXP_WAITS));
        if (apb.PREADY === 1'b1) begin
            if (wr) begin
                model[addr[4:0]] = data;
            end else begin
                exp_rd = exp_q.pop_front();
                check({tag, " rdata"}, apb.PRDATA, exp_rd);
            end
        end else if (!wr) begin
            void'(exp_q.pop_front());
        end
        $display("xfer %s %s addr=%0d data=0x%08h prdata=0x%08h waits=%0d",
                 tag, wr ? "WR" : "RD", addr, data, apb.PRDATA, waits);
        @(posedge pclk); #1;
        if (hold) begin
            // Bus still selected and enabled: the completer must not signal a second completion.
            @(negedge pclk);
            check({tag, " pready_one_cycle"}, 32'(apb.PREADY), 32'h0);
            @(posedge pclk); #1;
        end
        apb.PSELx   = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_model();
        presetn     = 1'b0;
        apb.PSELx   = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;

        #12;
        check("reset prdata", apb.PRDATA, 32'h0);
        check("reset pready", 32'(apb.PREADY), 32'h0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Read after reset, PREADY for exactly one cycle.
        xfer(1'b0, 32'd7, 32'h0, 1'b1, "rd7_after_reset");

        xfer(1'b1, 32'd2, 32'd999, 1'b0, "wr2_999");
        xfer(1'b0, 32'd2, 32'h0, 1'b0, "rd2");
        xfer(1'b0, 32'd6, 32'h0, 1'b0, "rd6");
        check("rd2 prdata held", apb.PRDATA, 32'h0);

        // Reset pulse between transfers clears storage and PRDATA asynchronously.
        xfer(1'b1, 32'd2, 32'd999, 1'b0, "wr2_999b");
        xfer(1'b0, 32'd2, 32'h0, 1'b0, "rd2_pre_reset");
        presetn = 1'b0;
        #2;
        check("async reset prdata", apb.PRDATA, 32'h0);
        #8;
        presetn = 1'b1;
        clear_model();
        xfer(1'b0, 32'd2, 32'h0, 1'b0, "rd2_post_reset");

        // Reset during ACCESS drops the write.
        apb.PSELx   = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 32'd5;
        apb.PWDATA  = 32'h77;
        @(posedge pclk); #1;
        apb.PENABLE = 1'b1;
        repeat (EXP_WAITS) @(posedge pclk);
        #2;
        presetn = 1'b0;
        #1;
        check("midxfer reset pready", 32'(apb.PREADY), 32'h0);
        @(posedge pclk); #1;
        presetn     = 1'b1;
        apb.PSELx   = 1'b0;
        apb.PENABLE = 1'b0;
        $display("xfer midxfer_reset WR addr=5 data=0x00000077 aborted by reset");
        clear_model();
        xfer(1'b0, 32'd5, 32'h0, 1'b0, "rd5_after_abort");

        // PENABLE high straight from IDLE is ignored.
        xfer(1'b1, 32'd2, 32'd999, 1'b0, "wr2_999c");
        apb.PSELx   = 1'b1;
        apb.PENABLE = 1'b1;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 32'd2;
        apb.PWDATA  = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("violation pready", 32'(apb.PREADY), 32'h0);
        end
        @(posedge pclk); #1;
        apb.PSELx   = 1'b0;
        apb.PENABLE = 1'b0;
        $display("xfer violation WR addr=2 data=0x0000dead without SETUP");
        xfer(1'b0, 32'd2, 32'h0, 1'b0, "rd2_after_violation");
        check("violation keeps old value", apb.PRDATA, 32'd999);

        // Aliasing modulo DEPTH and back-to-back reads.
        xfer(1'b1, 32'd35, 32'd555, 1'b0, "wr35_555");
        xfer(1'b0, 32'd3, 32'h0, 1'b0, "rd3");
        xfer(1'b0, 32'd3, 32'h0, 1'b0, "rd3_b2b");
        check("alias value", apb.PRDATA, 32'd555);
        xfer(1'b0, 32'h0000_1023, 32'h0, 1'b0, "rd_alias_hi");

`ifdef APB_SLAVE_WAIT_EN
        xfer(1'b1, 32'd4, 32'h1234, 1'b0, "wait_wr4");
        xfer(1'b0, 32'd4, 32'h0, 1'b0, "wait_rd4");
        // Enable dropped after the first (waiting) ACCESS cycle: no commit.
        apb.PSELx   = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 32'd4;
        apb.PWDATA  = 32'hBEEF;
        @(posedge pclk); #1;
        apb.PENABLE = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        check("wait short pready", 32'(apb.PREADY), 32'h0);
        @(posedge pclk); #1;
        apb.PSELx   = 1'b0;
        apb.PENABLE = 1'b0;
        $display("xfer wait_short WR addr=4 data=0x0000beef enable dropped early");
        @(posedge pclk); #1;
        xfer(1'b0, 32'd4, 32'h0, 1'b0, "wait_rd4_after_short");
        check("wait short no commit", apb.PRDATA, 32'h1234);
`endif

        repeat (2) @(posedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
